// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer: FSM states and reset-cause codes.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR  = 2'b00;
  localparam cause_t CAUSE_EXT  = 2'b01;
  localparam cause_t CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/rst_sync_filt.sv
// Two-flop synchronizer plus low-glitch filter for an asynchronous active-low request.
module rst_sync_filt #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n,
  output logic valid
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(FILT_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] low_cnt;

  // NOTE: synchronizer flops reset high so power-on never masquerades as an external request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      low_cnt <= '0;
      valid   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_n};
      if (sync_q[1]) begin
        low_cnt <= '0;
        valid   <= 1'b0;
      end else begin
        // valid rises on the FILT_LEN-th consecutive low sample and holds while low persists
        valid <= (low_cnt >= LOW_LAST);
        if (low_cnt < LOW_LAST) low_cnt <= low_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: holds all channels low, then releases them one by one
// with a fixed gap; re-enters reset on power-on, filtered external or soft requests.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned HOLD_CYC  = 16'hFFFE,
  parameter int unsigned STAGE_GAP = 16,
  parameter int unsigned FILT_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_rst_n,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              ready,
  output cause_t            rst_cause
);

  if (NUM_CH < 1) begin : g_chk_ch
    $error("rst_seq: NUM_CH must be >= 1");
  end
  if (HOLD_CYC < 1 || longint'(HOLD_CYC) > ((longint'(1) << CNT_W) - 1)) begin : g_chk_hold
    $error("rst_seq: HOLD_CYC must be in 1 .. 2**CNT_W-1");
  end
  if (STAGE_GAP < 1 || longint'(STAGE_GAP) > ((longint'(1) << CNT_W) - 1)) begin : g_chk_gap
    $error("rst_seq: STAGE_GAP must be in 1 .. 2**CNT_W-1");
  end
  if (FILT_LEN < 1) begin : g_chk_filt
    $error("rst_seq: FILT_LEN must be >= 1");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   gap_cnt;
  logic               ext_valid;
  logic [NUM_CH-1:0]  nxt_mask;

  rst_sync_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_sync_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_n (ext_rst_n),
    .valid   (ext_valid)
  );

  // Next release pattern: one more channel high, starting from bit 0 (all low in ASSERT).
  assign nxt_mask = (rst_n_o << 1) | NUM_CH'(1);

  // NOTE: all sequencer state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ASSERT;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      rst_n_o   <= '0;
      ready     <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else if (ext_valid) begin
      // External request wins over everything, including a coincident soft request.
      state     <= ST_ASSERT;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      rst_n_o   <= '0;
      ready     <= 1'b0;
      rst_cause <= CAUSE_EXT;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            gap_cnt  <= '0;
            rst_n_o  <= nxt_mask;
            state    <= (&nxt_mask) ? ST_RUN : ST_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            rst_n_o <= nxt_mask;
            if (&nxt_mask) state <= ST_RUN;
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (soft_rst_req) begin
            state     <= ST_ASSERT;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            rst_n_o   <= '0;
            ready     <= 1'b0;
            rst_cause <= CAUSE_SOFT;
          end else begin
            ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_ASSERT;
          hold_cnt <= '0;
          gap_cnt  <= '0;
          rst_n_o  <= '0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
